// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer driving a 4-bit pc and gated write strobes.
// Build with SEQ_SINGLE_STEP_EN to add a PAUSE state released by step.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  output logic        imem_req,
  output logic [3:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] op,
  input  logic        dec_pc_we,
  input  logic        dec_reg_we,
  input  logic        dec_mem_we,
  input  logic [3:0]  dec_pc_in,
  output logic [3:0]  pc,
  output logic        reg_we,
  output logic        mem_we,
  output logic        busy,
  output logic        halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
`ifdef SEQ_SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd5;
  localparam logic [2:0] S_AFTER  = S_PAUSE;
`else
  localparam logic [2:0] S_AFTER  = S_FETCH;
  logic w_step_unused;
  assign w_step_unused = step;
`endif

  logic [2:0]  r_state;
  logic [3:0]  r_pc;
  logic [31:0] r_op;
  logic        r_pc_we;
  logic [3:0]  r_pc_in;
  logic        r_reg_we;
  logic        r_mem_we;

  logic w_exec;
  logic w_halt_op;

  assign w_exec    = (r_state == S_EXEC);
  assign w_halt_op = (r_op[31:28] == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= 4'h0;
      r_op     <= 32'h0;
      r_pc_we  <= 1'b0;
      r_pc_in  <= 4'h0;
      r_reg_we <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= 4'h0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_op    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_pc_we  <= dec_pc_we;
          r_pc_in  <= dec_pc_in;
          r_reg_we <= dec_reg_we;
          r_mem_we <= dec_mem_we;
          r_state  <= w_halt_op ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          // 4-bit add wraps 4'hF to 4'h0 naturally
          r_pc    <= r_pc_we ? r_pc_in : r_pc + 4'h1;
          r_state <= S_AFTER;
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step) r_state <= S_FETCH;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign op        = r_op;
  assign reg_we    = w_exec & r_reg_we;
  assign mem_we    = w_exec & r_mem_we;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);

endmodule
